// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: bias, special encodings, flag layout.
package fpu_pkg;

   localparam int          FP32_BIAS    = 127;
   localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
   localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

   // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
   localparam int FLG_INVALID = 3;
   localparam int FLG_OVF     = 2;
   localparam int FLG_UNF     = 1;
   localparam int FLG_INX     = 0;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit significand with guard and sticky bits.
// On a carry out of the all-ones significand the result is returned as 1.0
// (hidden bit only) so the caller just bumps its exponent.
module fp_round_rne
   import fpu_pkg::*;
(
   input  logic [23:0] mant_i,
   input  logic        guard_i,
   input  logic        sticky_i,
   output logic [23:0] mant_o,
   output logic        carry_o,
   output logic        inexact_o
);

   logic        inc;
   logic [24:0] sum;

   // Increment on more-than-half, or exactly half with an odd LSB
   always_comb begin
      inc       = guard_i & (sticky_i | mant_i[0]);
      sum       = {1'b0, mant_i} + {24'd0, inc};
      carry_o   = sum[24];
      mant_o    = sum[24] ? 24'h800000 : sum[23:0];
      inexact_o = guard_i | sticky_i;
   end

endmodule

// File: rtl/fp_mul_round_normalize.sv
// Post-multiply stage: normalize (stage 1), round-to-nearest-even and pack
// a binary32 result with exception flags (stage 2). Valid/ready on both
// sides; in_ready depends combinationally on out_ready.
module fp_mul_round_normalize
   import fpu_pkg::*;
#(
   parameter int BIAS   = FP32_BIAS,
   parameter int EXP_W  = 10,
   parameter int MANT_W = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp_sum,
   input  logic [MANT_W-1:0] in_mant_prod,
   input  logic              in_zero,
   input  logic              in_inf,
   input  logic              in_nan,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic [3:0]        out_flags
);

   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
   localparam logic signed [EW-1:0] ONE_S  = EW'(1);
   localparam logic signed [EW-1:0] ZERO_S = '0;
   localparam logic signed [EW-1:0] EMAX_S = {{(EW-8){1'b0}}, FP32_EXP_MAX};

   // Handshake
   logic s1_adv;
   logic s2_adv;

   // Stage 1 registers and their next values
   logic                 s1_valid_q;
   logic                 s1_sign_q,   s1_sign_d;
   logic signed [EW-1:0] s1_e_q,      s1_e_d;
   logic [24:0]          s1_mant_q,   s1_mant_d;
   logic                 s1_sticky_q, s1_sticky_d;
   logic                 s1_zero_q,   s1_zero_d;
   logic                 s1_inf_q,    s1_inf_d;
   logic                 s1_nan_q,    s1_nan_d;

   // Stage 2 registers and their next values
   logic                 s2_valid_q;
   logic [31:0]          out_result_q, out_result_d;
   logic [3:0]           out_flags_q,  out_flags_d;

   // Normalized product (leading one moved to the top bit)
   logic [MANT_W-1:0]    m_norm;
   logic                 prod_msb;

   // Rounder outputs
   logic [23:0]          mant_rnd;
   logic                 rnd_carry;
   logic                 rnd_inexact;
   logic signed [EW-1:0] e_rnd;
   fp32_t                res_pack;
   logic                 unused_hidden;

   assign s2_adv    = !s2_valid_q || out_ready;
   assign s1_adv    = !s1_valid_q || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign out_result = out_result_q;
   assign out_flags  = out_flags_q;

   assign prod_msb = in_mant_prod[MANT_W-1];

   // One-bit left shift when the product is below 2.0; bit 0 fills with zero
   for (genvar gi = 0; gi < MANT_W; gi++) begin : g_norm
      if (gi == 0) begin : g_lsb
         assign m_norm[gi] = prod_msb & in_mant_prod[0];
      end else begin : g_bit
         assign m_norm[gi] = prod_msb ? in_mant_prod[gi] : in_mant_prod[gi-1];
      end
   end

   // Stage 1 next state: unbiased exponent, 25-bit significand+guard, sticky
   always_comb begin
      s1_sign_d   = in_sign;
      s1_e_d      = $signed({2'b00, in_exp_sum}) - BIAS_S + (prod_msb ? ONE_S : ZERO_S);
      s1_mant_d   = m_norm[MANT_W-1 -: 25];
      s1_sticky_d = |m_norm[MANT_W-26:0];
      s1_zero_d   = in_zero;
      s1_inf_d    = in_inf;
      s1_nan_d    = in_nan;
   end

   // Stage 1 register: loads whenever it can advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_e_q      <= '0;
         s1_mant_q   <= '0;
         s1_sticky_q <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_inf_q    <= 1'b0;
         s1_nan_q    <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q   <= s1_sign_d;
            s1_e_q      <= s1_e_d;
            s1_mant_q   <= s1_mant_d;
            s1_sticky_q <= s1_sticky_d;
            s1_zero_q   <= s1_zero_d;
            s1_inf_q    <= s1_inf_d;
            s1_nan_q    <= s1_nan_d;
         end
      end
   end

   fp_round_rne u_rne (
      .mant_i    (s1_mant_q[24:1]),
      .guard_i   (s1_mant_q[0]),
      .sticky_i  (s1_sticky_q),
      .mant_o    (mant_rnd),
      .carry_o   (rnd_carry),
      .inexact_o (rnd_inexact)
   );

   // Hidden bit is implied in the packed format
   assign unused_hidden = mant_rnd[23];

   // Stage 2 next state: exponent adjust after rounding, then special-case priority
   always_comb begin
      e_rnd       = rnd_carry ? (s1_e_q + ONE_S) : s1_e_q;
      res_pack    = '0;
      out_flags_d = '0;
      if (s1_nan_q) begin
         res_pack                 = FP32_QNAN;
         out_flags_d[FLG_INVALID] = 1'b1;
      end else if (s1_inf_q) begin
         res_pack.sign = s1_sign_q;
         res_pack.exp  = FP32_EXP_MAX;
      end else if (s1_zero_q) begin
         res_pack.sign = s1_sign_q;
      end else if (e_rnd >= EMAX_S) begin
         res_pack.sign        = s1_sign_q;
         res_pack.exp         = FP32_EXP_MAX;
         out_flags_d[FLG_OVF] = 1'b1;
         out_flags_d[FLG_INX] = 1'b1;
      end else if (e_rnd <= ZERO_S) begin
         res_pack.sign        = s1_sign_q;
         out_flags_d[FLG_UNF] = 1'b1;
         out_flags_d[FLG_INX] = 1'b1;
      end else begin
         res_pack.sign        = s1_sign_q;
         res_pack.exp         = e_rnd[7:0];
         res_pack.frac        = mant_rnd[22:0];
         out_flags_d[FLG_INX] = rnd_inexact;
      end
      out_result_d = res_pack;
   end

   // Stage 2 register: holds result stable while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q   <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= '0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_round_normalize.sv
// Directed bench for the post-multiply normalize/round/pack pipeline.
module tb_fp_mul_round_normalize;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp_sum;
   logic [47:0] in_mant_prod;
   logic        in_zero;
   logic        in_inf;
   logic        in_nan;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   logic        bp_s[4];
   logic [9:0]  bp_e[4];
   logic [47:0] bp_p[4];
   int          idx;
   int          got;
   logic [31:0] popped;

   fp_mul_round_normalize dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_exp_sum   (in_exp_sum),
      .in_mant_prod (in_mant_prod),
      .in_zero      (in_zero),
      .in_inf       (in_inf),
      .in_nan       (in_nan),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_flags    (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Exact real-valued reference; vectors are chosen to be exactly representable
   function automatic logic [31:0] model(input logic s, input logic [9:0] es, input logic [47:0] p);
      real         r;
      logic [63:0] b;
      logic [10:0] e11;
      int          sh;
      r  = real'(p);
      sh = int'(es) - 254 - 46;
      while (sh > 0) begin r = r * 2.0; sh--; end
      while (sh < 0) begin r = r / 2.0; sh++; end
      if (s) r = -r;
      b   = $realtobits(r);
      e11 = b[62:52] - 11'd896;
      return {b[63], e11[7:0], b[51:29]};
   endfunction

   // Single transaction with out_ready high; entered and left at posedge+1
   task automatic run_one(input string tag, input logic s, input logic [9:0] es,
                          input logic [47:0] p, input logic z, input logic inf, input logic nan,
                          input logic [31:0] exp_res, input logic [3:0] exp_flg);
      in_valid = 1'b1; in_sign = s; in_exp_sum = es; in_mant_prod = p;
      in_zero = z; in_inf = inf; in_nan = nan;
      #1;
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_latency"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_result"}, out_result, exp_res);
      check({tag, "_flags"}, {28'd0, out_flags}, {28'd0, exp_flg});
      $display("txn %s result=%h flags=%b", tag, out_result, out_flags);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_sign = 1'b0; in_exp_sum = '0; in_mant_prod = '0;
      in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_flags", {28'd0, out_flags}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Arithmetic and rounding
      run_one("mul_1p5x2p5",  1'b0, 10'd255, 48'h780000000000, 0, 0, 0, 32'h40700000, 4'b0000);
      run_one("mul_neg",      1'b1, 10'd257, 48'h780000000000, 0, 0, 0, 32'hC1700000, 4'b0000);
      run_one("mul_2x2",      1'b0, 10'd256, 48'h400000000000, 0, 0, 0, 32'h40800000, 4'b0000);
      run_one("rne_tie_even", 1'b0, 10'd254, 48'h400000400000, 0, 0, 0, 32'h3F800000, 4'b0001);
      run_one("rne_tie_odd",  1'b0, 10'd254, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 4'b0001);
      run_one("rne_sticky",   1'b0, 10'd254, 48'h400000600000, 0, 0, 0, 32'h3F800001, 4'b0001);
      run_one("rne_carry",    1'b0, 10'd254, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 4'b0001);
      // Exponent range boundaries
      run_one("ovf_big",      1'b0, 10'd508, 48'h400000000000, 0, 0, 0, 32'h7F800000, 4'b0101);
      run_one("e254_exact",   1'b0, 10'd381, 48'h400000000000, 0, 0, 0, 32'h7F000000, 4'b0000);
      run_one("e254_round",   1'b0, 10'd381, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 4'b0101);
      run_one("unf_pos",      1'b0, 10'd100, 48'h400000000000, 0, 0, 0, 32'h00000000, 4'b0011);
      run_one("unf_neg",      1'b1, 10'd100, 48'h400000000000, 0, 0, 0, 32'h80000000, 4'b0011);
      run_one("unf_exp0",     1'b0, 10'd0,   48'h400000000000, 0, 0, 0, 32'h00000000, 4'b0011);
      run_one("e0_flush",     1'b0, 10'd127, 48'h400000000000, 0, 0, 0, 32'h00000000, 4'b0011);
      run_one("e1_min",       1'b0, 10'd128, 48'h400000000000, 0, 0, 0, 32'h00800000, 4'b0000);
      // Specials and their priority
      run_one("nan",          1'b1, 10'd508, 48'h400000000000, 1, 1, 1, 32'h7FC00000, 4'b1000);
      run_one("inf_neg",      1'b1, 10'd254, 48'h400000000000, 1, 1, 0, 32'hFF800000, 4'b0000);
      run_one("zero_neg",     1'b1, 10'd254, 48'h000000000000, 1, 0, 0, 32'h80000000, 4'b0000);

      // Backpressure: 6 stalled cycles while 4 inputs are offered back-to-back
      bp_s[0] = 1'b0; bp_e[0] = 10'd255; bp_p[0] = 48'h780000000000;
      bp_s[1] = 1'b1; bp_e[1] = 10'd257; bp_p[1] = 48'h780000000000;
      bp_s[2] = 1'b0; bp_e[2] = 10'd256; bp_p[2] = 48'h400000000000;
      bp_s[3] = 1'b0; bp_e[3] = 10'd250; bp_p[3] = 48'h600000000000;
      idx = 0; got = 0;
      in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
         out_ready = (cyc >= 6);
         if (idx < 4) begin
            in_valid = 1'b1; in_sign = bp_s[idx]; in_exp_sum = bp_e[idx]; in_mant_prod = bp_p[idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc == 2) check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
         if (cyc == 5) check("bp_accepts", 32'(idx), 32'd2);
         if (cyc >= 2 && cyc <= 5) begin
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_result", out_result, 32'h40700000);
         end
         if (cyc == 6) check("bp_shift_in_ready", {31'd0, in_ready}, 32'd1);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("bp_unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
               popped = exp_q.pop_front();
               check("bp_order", out_result, popped);
               $display("txn bp%0d result=%h flags=%b", got, out_result, out_flags);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_sign, in_exp_sum, in_mant_prod));
            idx++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_received", 32'(got), 32'd4);
      @(posedge clk); #1;

      // Reset while both stages are full and stalled
      out_ready = 1'b0;
      in_valid = 1'b1; in_sign = 1'b0; in_exp_sum = 10'd256; in_mant_prod = 48'h400000000000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("rs_full_valid", {31'd0, out_valid}, 32'd1);
      check("rs_full_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rs_out_valid", {31'd0, out_valid}, 32'd0);
      check("rs_in_ready", {31'd0, in_ready}, 32'd1);
      check("rs_out_result", out_result, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("rs_no_stale", {31'd0, out_valid}, 32'd0);
      end
      $display("txn reset_mid_stall out_valid=%b in_ready=%b", out_valid, in_ready);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
